data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the single-cycle ARM core's load/store port.
- Decodes the core's byte address (ALU result) together with store data and read/write strobes.
- Serves word-wide RAM plus a memory-mapped peripheral page: GPIO output, synchronized GPIO input, a 32-bit timer with compare, and sticky status flags.
- Read data is returned combinationally in the same cycle; all writes commit on the rising edge of CLK.

Parameters:
- RAM_DEPTH, 64, number of 32-bit RAM words; must be a power of two, minimum 4.
- IO_WIDTH, 16, width of the GPIO output and input ports, 1..32.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  store strobe for the current cycle.
- MemRead  input  1  load strobe for the current cycle (core's MemtoReg).
- Addr  input  32  byte address from the core's ALU result.
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational.
- io_out  output  IO_WIDTH  GPIO output register.
- io_in  input  IO_WIDTH  asynchronous GPIO input.
- irq  output  1  equals STATUS.match.

Behaviour:
- Reset is synchronous and active-high. On the first rising CLK edge with reset=1:
  - io_out, the timer, CMP, STATUS and both io_in synchronizer stages all become 0.
  - RAM contents are not cleared.
  - While reset=1, the timer holds at 0 and all writes are ignored.
- RAM region, Addr < RAM_DEPTH*4:
  - Word index is Addr[log2(RAM_DEPTH)+1:2].
- Peripheral page, Addr[31:8] = 0x800000:
  - 0x00 IO_OUT, R/W. Write stores WriteData[IO_WIDTH-1:0]; read returns it zero-extended.
  - 0x04 IO_IN, read-only. Returns the 2-flop-synchronized io_in, so latency is 2 cycles from the pin to a readable value. Writes are ignored without error.
  - 0x08 TIMER, R/W.
    - Increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
    - A write loads WriteData. On a write cycle the written value replaces the increment (next value = WriteData, not WriteData+1).
  - 0x0C CMP, R/W, 32 bits.
  - 0x10 STATUS.
    - bit0 = match, bit1 = err; other bits read 0.
    - Write-1-to-clear per bit.
- Any other address is unmapped.
- Match: when the timer's next value equals CMP, match sets on that edge. This also applies when the next value comes from a TIMER write. irq = match.
- Error flag err is sticky and is set on the edge when any of these occurs:
  - (MemWrite or MemRead) with Addr[1:0] != 0;
  - (MemWrite or MemRead) with an unmapped address;
  - MemWrite and MemRead both 1.
- Erroring accesses:
  - An erroring write is discarded and has no side effect anywhere.
  - An erroring read returns 0.
  - When both strobes are 1, the write is discarded and ReadData = 0.
- ReadData is 0 whenever MemRead = 0. This avoids decoding garbage ALU results on non-load cycles, and such cycles never set err.
- Read-during-write to the same address returns the old contents; the new value is visible from the next cycle.
- Simultaneous set and clear in STATUS: the set wins (the flag stays 1).

Test Plan:
- Reset, then MemWrite at Addr 0x0000000C with data 0xDEADBEEF. Next cycle, MemRead at 0x0C -> ReadData = 0xDEADBEEF. Addr 0x10 reads the prior contents, and err stays 0.
- Same-cycle read/write: write 0x1111 then 0x2222 to RAM word 3 on consecutive cycles while reading word 3. ReadData must be:
  - the old value during the 0x1111 write cycle;
  - 0x1111 during the 0x2222 write cycle;
  - 0x2222 afterwards.
- Timer write, then read: write TIMER = 5 at cycle N, then read TIMER at cycle N+3 -> 7.
- Timer wrap: write TIMER = 0xFFFFFFFE; two cycles later it reads 0x00000000.
- Compare match:
  - CMP = 20, TIMER written to 10 -> irq rises exactly 10 cycles after the write edge.
  - Write 0x1 to STATUS -> irq = 0 next cycle.
  - Clear on the same edge as a new match -> irq stays 1.
- Error cases, each setting err on its own edge:
  - misaligned MemRead at Addr 0x6 -> ReadData = 0, err = 1;
  - MemWrite to unmapped 0x40000000 -> no state change, err = 1;
  - both strobes high -> write discarded, ReadData = 0.
- GPIO:
  - io_in = 0xA5A5 applied asynchronously -> IO_IN reads 0xA5A5 two cycles later.
  - Write 0x1234 to IO_OUT -> io_out = 0x1234 after the edge.
  - Assert reset with MemWrite=1 -> io_out = 0, write ignored, RAM keeps its prior contents.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Core-side load/store port: byte address, store data, strobes and combinational load data.
interface data_mem_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output MemRead,
    output Addr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  MemRead,
    input  Addr,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/data_mem_responder.sv
// Load/store responder: word RAM plus GPIO/timer/status page; reads are combinational, writes commit on CLK.
// No backpressure: every access completes in its own cycle; bad accesses set a sticky err flag instead.
module data_mem_responder #(
  parameter int RAM_DEPTH = 64,
  parameter int IO_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  data_mem_responder_if.slave   mem,
  output logic [IO_WIDTH-1:0]   io_out,
  input  logic [IO_WIDTH-1:0]   io_in,
  output logic                  irq
);

  localparam int AW = $clog2(RAM_DEPTH);

  localparam logic [23:0] PAGE_BASE  = 24'h800000;
  localparam logic [7:0]  OFS_IO_OUT = 8'h00;
  localparam logic [7:0]  OFS_IO_IN  = 8'h04;
  localparam logic [7:0]  OFS_TIMER  = 8'h08;
  localparam logic [7:0]  OFS_CMP    = 8'h0C;
  localparam logic [7:0]  OFS_STATUS = 8'h10;

  logic [31:0]         r_ram [RAM_DEPTH];
  logic [IO_WIDTH-1:0] r_io_out;
  logic [IO_WIDTH-1:0] r_sync1;
  logic [IO_WIDTH-1:0] r_sync2;
  logic [31:0]         r_timer;
  logic [31:0]         r_cmp;
  logic                r_match;
  logic                r_err;

  logic          w_aligned;
  logic          w_ram_hit;
  logic          w_page_hit;
  logic          w_sel_io_out;
  logic          w_sel_io_in;
  logic          w_sel_timer;
  logic          w_sel_cmp;
  logic          w_sel_status;
  logic          w_mapped;
  logic          w_access;
  logic          w_err;
  logic          w_wr;
  logic          w_rd;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_io_out_ext;
  logic [31:0]   w_io_in_ext;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic [31:0]   w_timer_nxt;
  logic          w_match_set;
  logic [1:0]    w_clr;

  // Address decode and error qualification
  always_comb begin
    w_aligned    = (mem.Addr[1:0] == 2'b00);
    w_ram_hit    = (mem.Addr[31:AW+2] == '0);
    w_page_hit   = (mem.Addr[31:8] == PAGE_BASE);
    w_sel_io_out = w_page_hit && (mem.Addr[7:0] == OFS_IO_OUT);
    w_sel_io_in  = w_page_hit && (mem.Addr[7:0] == OFS_IO_IN);
    w_sel_timer  = w_page_hit && (mem.Addr[7:0] == OFS_TIMER);
    w_sel_cmp    = w_page_hit && (mem.Addr[7:0] == OFS_CMP);
    w_sel_status = w_page_hit && (mem.Addr[7:0] == OFS_STATUS);
    w_mapped     = w_ram_hit | w_sel_io_out | w_sel_io_in | w_sel_timer |
                   w_sel_cmp | w_sel_status;
    w_access     = mem.MemWrite | mem.MemRead;
    w_err        = w_access &&
                   (!w_aligned || !w_mapped || (mem.MemWrite && mem.MemRead));
    w_wr         = mem.MemWrite && !w_err;
    w_rd         = mem.MemRead && !w_err;
    w_idx        = mem.Addr[AW+1:2];
  end

  always_comb begin
    w_io_out_ext                 = '0;
    w_io_out_ext[IO_WIDTH-1:0]   = r_io_out;
    w_io_in_ext                  = '0;
    w_io_in_ext[IO_WIDTH-1:0]    = r_sync2;
    w_status                     = {30'd0, r_err, r_match};
  end

  // Read mux; the array read sees pre-edge contents, so read-during-write returns old data
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      if (w_ram_hit)         w_rdata = r_ram[w_idx];
      else if (w_sel_io_out) w_rdata = w_io_out_ext;
      else if (w_sel_io_in)  w_rdata = w_io_in_ext;
      else if (w_sel_timer)  w_rdata = r_timer;
      else if (w_sel_cmp)    w_rdata = r_cmp;
      else if (w_sel_status) w_rdata = w_status;
    end
  end

  assign mem.ReadData = w_rdata;

  // A TIMER write replaces the increment, and match compares against that same next value
  always_comb begin
    w_timer_nxt = (w_wr && w_sel_timer) ? mem.WriteData : r_timer + 32'd1;
    w_match_set = (w_timer_nxt == r_cmp);
    w_clr       = (w_wr && w_sel_status) ? mem.WriteData[1:0] : 2'b00;
  end

  always_ff @(posedge CLK) begin
    if (!reset && w_wr && w_ram_hit) begin
      r_ram[w_idx] <= mem.WriteData;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_io_out <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_timer  <= '0;
      r_cmp    <= '0;
      r_match  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;
      r_timer <= w_timer_nxt;
      if (w_wr && w_sel_io_out) r_io_out <= mem.WriteData[IO_WIDTH-1:0];
      if (w_wr && w_sel_cmp)    r_cmp    <= mem.WriteData;
      // Set has priority over a same-edge write-1-to-clear
      r_match <= w_match_set | (r_match & ~w_clr[0]);
      r_err   <= w_err       | (r_err   & ~w_clr[1]);
    end
  end

  assign io_out = r_io_out;
  assign irq    = r_match;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, timer/compare, status, errors, GPIO and reset.
module tb_data_mem_responder;

  localparam logic [31:0] A_IO_OUT = 32'h8000_0000;
  localparam logic [31:0] A_IO_IN  = 32'h8000_0004;
  localparam logic [31:0] A_TIMER  = 32'h8000_0008;
  localparam logic [31:0] A_CMP    = 32'h8000_000C;
  localparam logic [31:0] A_STATUS = 32'h8000_0010;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        irq;
  int          checks   = 0;
  int          failures = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .RAM_DEPTH (64),
    .IO_WIDTH  (16)
  ) dut (
    .CLK    (CLK),
    .reset  (reset),
    .mem    (bus),
    .io_out (io_out),
    .io_in  (io_in),
    .irq    (irq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Addr      = 32'd0;
    bus.WriteData = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    bus.Addr      = a;
    bus.WriteData = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.Addr     = a;
    #1;
    chk(tag, bus.ReadData, exp);
    bus.MemRead  = 1'b0;
    bus.Addr     = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    io_in = 16'h0000;
    idle();
    step();
    step();
    reset = 1'b0;

    // reset state
    chk("rst_io_out", 32'(io_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h0, "rst_status");
    rd(A_TIMER, 32'h0, "rst_timer");
    rd(A_IO_OUT, 32'h0, "rst_io_out_rd");
    wr(A_CMP, 32'hFFFF_0000);

    // RAM write then read back
    wr(32'h0000_0000, 32'hA0A0_A0A0);
    wr(32'h0000_0010, 32'h4444_4444);
    wr(32'h0000_000C, 32'hDEAD_BEEF);
    rd(32'h0000_000C, 32'hDEAD_BEEF, "ram_w3");
    rd(32'h0000_0010, 32'h4444_4444, "ram_w4");
    rd(A_STATUS, 32'h0, "ram_no_err");

    // same-cycle read vs write: contents change only at the edge
    rd(32'h0000_000C, 32'hDEAD_BEEF, "rdw_old");
    wr(32'h0000_000C, 32'h0000_1111);
    rd(32'h0000_000C, 32'h0000_1111, "rdw_1111");
    wr(32'h0000_000C, 32'h0000_2222);
    rd(32'h0000_000C, 32'h0000_2222, "rdw_2222");

    // timer load and count
    wr(A_TIMER, 32'd5);
    rd(A_TIMER, 32'd5, "tmr_load");
    step();
    step();
    rd(A_TIMER, 32'd7, "tmr_plus2");

    // timer wrap
    wr(A_TIMER, 32'hFFFF_FFFE);
    rd(A_TIMER, 32'hFFFF_FFFE, "wrap_fe");
    step();
    rd(A_TIMER, 32'hFFFF_FFFF, "wrap_ff");
    step();
    rd(A_TIMER, 32'h0000_0000, "wrap_zero");
    chk("wrap_no_irq", 32'(irq), 32'h0);

    // compare match 10 edges after the TIMER write edge
    wr(A_CMP, 32'd20);
    wr(A_TIMER, 32'd10);
    repeat (9) step();
    chk("match_e9", 32'(irq), 32'h0);
    step();
    chk("match_e10", 32'(irq), 32'h1);
    rd(A_TIMER, 32'd20, "match_tmr");
    wr(A_STATUS, 32'h1);
    chk("match_clr", 32'(irq), 32'h0);

    // clear on the same edge as a new match: set wins
    wr(A_TIMER, 32'd100);
    wr(A_CMP, 32'd103);
    step();
    wr(A_STATUS, 32'h1);
    chk("set_wins", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h1);
    chk("clr_again", 32'(irq), 32'h0);
    wr(A_TIMER, 32'd103);
    chk("match_on_wr", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h3);
    wr(A_CMP, 32'hFFFF_0000);
    chk("irq_off", 32'(irq), 32'h0);

    // misaligned read
    bus.MemRead = 1'b1;
    bus.Addr    = 32'h0000_0006;
    #1;
    chk("mis_rd_data", bus.ReadData, 32'h0);
    step();
    idle();
    rd(A_STATUS, 32'h2, "mis_rd_err");
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, 32'h0, "err_cleared");

    // unmapped write has no side effect
    wr(32'h4000_0000, 32'h1234_5678);
    rd(A_STATUS, 32'h2, "unmap_err");
    rd(32'h0000_0000, 32'hA0A0_A0A0, "unmap_ram");
    wr(A_STATUS, 32'h2);

    // misaligned peripheral write discarded
    wr(32'h8000_0001, 32'h0000_FFFF);
    chk("mis_wr_io", 32'(io_out), 32'h0);
    rd(A_STATUS, 32'h2, "mis_wr_err");
    wr(A_STATUS, 32'h2);

    // both strobes
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    bus.Addr      = 32'h0000_000C;
    bus.WriteData = 32'h0000_3333;
    #1;
    chk("both_rdata", bus.ReadData, 32'h0);
    step();
    idle();
    rd(32'h0000_000C, 32'h0000_2222, "both_discard");
    rd(A_STATUS, 32'h2, "both_err");
    wr(A_STATUS, 32'h2);

    // no strobes: garbage address neither reads nor errors
    bus.Addr      = 32'h0000_0007;
    bus.WriteData = 32'hFFFF_FFFF;
    #1;
    chk("idle_rdata", bus.ReadData, 32'h0);
    step();
    idle();
    rd(A_STATUS, 32'h0, "idle_no_err");

    // GPIO input synchronizer
    #2;
    io_in = 16'hA5A5;
    step();
    rd(A_IO_IN, 32'h0, "gpio_in_1");
    step();
    rd(A_IO_IN, 32'h0000_A5A5, "gpio_in_2");

    // GPIO output and ignored IO_IN write
    wr(A_IO_OUT, 32'hFFFF_1234);
    chk("gpio_out_pin", 32'(io_out), 32'h0000_1234);
    rd(A_IO_OUT, 32'h0000_1234, "gpio_out_rd");
    wr(A_IO_IN, 32'h0000_FFFF);
    rd(A_STATUS, 32'h0, "io_in_wr_ok");
    rd(A_IO_IN, 32'h0000_A5A5, "io_in_keep");

    // reset with a pending write
    reset         = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.Addr      = 32'h0000_000C;
    bus.WriteData = 32'h0000_9999;
    step();
    reset = 1'b0;
    idle();
    chk("rst2_io_out", 32'(io_out), 32'h0);
    rd(32'h0000_000C, 32'h0000_2222, "rst2_ram");
    rd(A_IO_IN, 32'h0, "rst2_sync");
    rd(A_TIMER, 32'h0, "rst2_timer");
    chk("rst2_irq", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
